// File: rtl/mmult_result_reader_if.sv
// Bundle between the 3x3 matrix multiplier, the result reader and the
// downstream formatter.
//   mat_valid / C_mat     : result level-valid and packed matrix from the multiplier
//   out_valid / out_ready : element stream handshake
//   out_data, out_row, out_col, out_row_last, out_last : current element and position
//   busy / done / overrun : reader status
// master = the reader (consumes the result, drives the stream and status).
// slave  = the environment around it (multiplier plus downstream sink).
interface mmult_result_reader_if #(
  parameter int N      = 3,
  parameter int ELEM_W = 17
);
  logic                    mat_valid;
  logic [0:N*N*ELEM_W-1]   C_mat;
  logic                    out_valid;
  logic                    out_ready;
  logic [ELEM_W-1:0]       out_data;
  logic [1:0]              out_row;
  logic [1:0]              out_col;
  logic                    out_row_last;
  logic                    out_last;
  logic                    busy;
  logic                    done;
  logic                    overrun;

  modport master (
    input  mat_valid, C_mat, out_ready,
    output out_valid, out_data, out_row, out_col, out_row_last, out_last,
           busy, done, overrun
  );

  modport slave (
    output mat_valid, C_mat, out_ready,
    input  out_valid, out_data, out_row, out_col, out_row_last, out_last,
           busy, done, overrun
  );
endinterface

// File: rtl/mmult_result_reader.sv
// Consumer side of the NxN matrix-multiplier result interface. Captures the
// packed result on a rising mat_valid, keeps a private copy, and streams the
// elements row-major over a valid/ready handshake.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mmult_result_reader_if.master (result in, element stream out, status)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a rising mat_valid; no element presented
// S_SEND | presenting buffer element k; k advances on each transfer
// S_DONE | one-cycle done pulse after the last transfer, still busy
module mmult_result_reader #(
  parameter int N      = 3,
  parameter int ELEM_W = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  mmult_result_reader_if.master bus
);
  localparam int NE   = N * N;
  localparam int K_W  = (NE > 1) ? $clog2(NE) : 1;
  localparam int RC_W = 2;
  localparam logic [K_W-1:0] K_LAST = K_W'(NE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ELEM_W-1:0] buf_q [NE];
  logic [ELEM_W-1:0] buf_d [NE];
  logic              mat_valid_q;
  logic              overrun_q, overrun_d;

  logic capture;
  logic xfer;

  assign capture = bus.mat_valid & ~mat_valid_q;
  assign xfer    = (state_q == S_SEND) & bus.out_ready;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      mat_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NE; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mat_valid_q <= bus.mat_valid;
      overrun_q   <= overrun_d;
      for (int i = 0; i < NE; i++) buf_q[i] <= buf_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (capture) state_d = S_SEND;
      S_SEND:  if (xfer && (k_q == K_LAST)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer, element index and overrun update
  always_comb begin
    k_d = k_q;
    for (int i = 0; i < NE; i++) buf_d[i] = buf_q[i];
    // A rising mat_valid outside IDLE is dropped; the running stream keeps its copy.
    overrun_d = overrun_q | (capture & (state_q != S_IDLE));
    if ((state_q == S_IDLE) && capture) begin
      k_d = '0;
      // Ascending C_mat: element i's MSB sits at bit i*ELEM_W.
      for (int i = 0; i < NE; i++) buf_d[i] = bus.C_mat[i*ELEM_W +: ELEM_W];
    end else if (xfer && (k_q != K_LAST)) begin
      k_d = k_q + 1'b1;
    end
  end

  // Outputs; position fields are gated so IDLE/DONE present all zeros.
  always_comb begin
    bus.out_valid    = 1'b0;
    bus.out_data     = '0;
    bus.out_row      = '0;
    bus.out_col      = '0;
    bus.out_row_last = 1'b0;
    bus.out_last     = 1'b0;
    bus.busy         = (state_q != S_IDLE);
    bus.done         = (state_q == S_DONE);
    bus.overrun      = overrun_q;
    if (state_q == S_SEND) begin
      bus.out_valid    = 1'b1;
      bus.out_data     = buf_q[k_q];
      bus.out_row      = RC_W'(k_q / K_W'(N));
      bus.out_col      = RC_W'(k_q % K_W'(N));
      bus.out_row_last = ((k_q % K_W'(N)) == K_W'(N - 1));
      bus.out_last     = (k_q == K_LAST);
    end
  end
endmodule
